mem_bus_scheduler: RTL and testbench
====================================

Name: mem_bus_scheduler

Overview:
- Shares the CPU's single nibble-wide external memory port between three requesters: instruction prefetch, data read and data write.
- Serializes each granted transaction onto tx_out.
- Tracks outstanding read responses in a small message-type FIFO, and routes each returning byte to the prefetcher or the scheduler/ALU side.
- Sits between the decoder/scheduler and the top-level uio/uo pins. Jump flushes invalidate in-flight prefetches.

Parameters:
- FIFO_DEPTH, 4: max outstanding read/prefetch transactions (power of two, >=2).
- ADDR_BITS, 16: address width; must be a multiple of 4.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- pf_req  in  1  prefetch request; held with pf_addr until pf_ack
- pf_addr  in  ADDR_BITS  prefetch address
- pf_ack  out  1  prefetch accepted this cycle
- pf_flush  in  1  one-cycle pulse on jump: discard outstanding prefetches
- rd_req  in  1  data read request
- rd_addr  in  ADDR_BITS  data read address
- rd_ack  out  1  read accepted this cycle
- wr_req  in  1  data write request
- wr_addr  in  ADDR_BITS  write address
- wr_data  in  8  write byte
- wr_ack  out  1  write accepted this cycle
- tx_out  out  4  nibble stream to pins
- tx_active  out  1  high while a transaction is being sent
- rx_valid  in  1  one response byte returned this cycle
- rx_data  in  8  response byte
- pf_resp_valid  out  1  rx byte belongs to a live prefetch
- rd_resp_valid  out  1  rx byte belongs to a data read
- resp_data  out  8  equals rx_data
- outstanding  out  log2(FIFO_DEPTH)+1  FIFO occupancy
- proto_error  out  1  sticky: rx_valid while FIFO is empty

Behaviour:
- Message types, 2 bits, stored in the FIFO:
  - MSG_PF = 1
  - MSG_RD = 2
  - MSG_DISCARD = 3
- tx header types:
  - TX_PF = 01
  - TX_RD = 10
  - TX_WR = 11
- Reset values:
  - all acks 0, tx_out 0, tx_active 0
  - FIFO empty, outstanding 0, proto_error 0
  - state IDLE
  - Reset mid-send aborts the transaction immediately with no partial completion.
- States: IDLE, SEND.
- Accept in IDLE, in priority order:
  - wr_req first.
  - Then rd_req, only if outstanding < FIFO_DEPTH.
  - Then pf_req, only if outstanding < FIFO_DEPTH and pf_flush is 0.
- Accept timing:
  - ack is combinational and lasts one cycle.
  - On accept, the block latches address and data and loads the nibble counter.
  - A read or prefetch pushes MSG_RD or MSG_PF in the accept cycle.
  - A write pushes nothing.
- No accept is possible in SEND. Back-to-back transactions are therefore separated by one IDLE cycle.
- SEND sequence, starting the cycle after accept:
  - Header nibble {2'b10, type}.
  - Then ADDR_BITS/4 address nibbles, LSB first.
  - For writes, then 2 data nibbles, low nibble first.
  - Total: read = 5 cycles, write = 7 cycles (default ADDR_BITS).
  - tx_active = 1 exactly during these cycles.
  - tx_out = 0 whenever tx_active = 0.
- Response handling (combinational, on rx_valid):
  - Pop the FIFO head.
  - Head MSG_PF: pf_resp_valid = 1, unless pf_flush is asserted this cycle.
  - Head MSG_RD: rd_resp_valid = 1.
  - Head MSG_DISCARD: byte dropped, no valid asserted.
  - resp_data = rx_data at all times.
- Flush: in the pf_flush cycle, every MSG_PF entry in the FIFO (including any popped this cycle) becomes MSG_DISCARD. MSG_RD entries are untouched.
- Simultaneous push and pop:
  - Allowed; outstanding stays unchanged.
  - Accept is gated on the registered occupancy, so a pop in the same cycle does not enable an accept at full.
- FIFO pointers wrap modulo FIFO_DEPTH.
- rx_valid with an empty FIFO: no pop, no valid, proto_error set until reset.
- Starvation of pf by back-to-back data requests is acceptable: the scheduler never issues more than one data request per instruction.

Decomposition:
- Shared header (common.vh):
  - MSG_* encodings and MSG_TYPE_BITS = 2
  - TX_* header encodings
- Sub-module msg_type_fifo:
  - depth/width parameterized; push, pop, count
  - flush-rewrite port: bulk replace of one value with another
  - entries visible for bench probing as entries[i]

Test Plan:
- Reset then rd_req with rd_addr=0x1234:
  - rd_ack in the same cycle.
  - tx_out = 0xA, 4, 3, 2, 1 over the next 5 cycles; outstanding = 1.
  - rx_valid with rx_data=0x5A → rd_resp_valid=1, resp_data=0x5A, outstanding = 0.
- wr_req with addr=0x00F0, data=0xC3 alongside pf_req:
  - wr_ack first; tx_out = B,0,F,0,0,3,C.
  - One idle cycle, then pf_ack; header 0x9.
- Four prefetches accepted, fifth pf_req held:
  - No pf_ack while outstanding = 4.
  - One rx_valid → pf_resp_valid; pf_ack one cycle later.
- Prefetch, read, prefetch outstanding, then pf_flush:
  - 3 rx bytes → rd_resp_valid only on the 2nd byte.
  - pf_resp_valid never asserted.
- pf_flush coinciding with rx_valid at a MSG_PF head → byte dropped; pf_req held in the same cycle is not acked.
- rx_valid while empty → proto_error = 1, held. rst_n low mid-write → tx_active = 0 next cycle, outstanding = 0, proto_error = 0.

Source files
------------

// File: rtl/mem_bus_scheduler_pkg.sv
// Shared encodings for the external memory port scheduler: FIFO message
// types, serial header types and the scheduler state type.
package mem_bus_scheduler_pkg;

  localparam int MSG_TYPE_BITS = 2;

  typedef logic [MSG_TYPE_BITS-1:0] msg_t;

  localparam msg_t MSG_NONE    = 2'd0;
  localparam msg_t MSG_PF      = 2'd1;
  localparam msg_t MSG_RD      = 2'd2;
  localparam msg_t MSG_DISCARD = 2'd3;

  localparam logic [1:0] TX_PF = 2'b01;
  localparam logic [1:0] TX_RD = 2'b10;
  localparam logic [1:0] TX_WR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // First nibble of every transaction on the pins.
  function automatic logic [3:0] tx_header(input logic [1:0] kind);
    return {2'b10, kind};
  endfunction

endpackage

// File: rtl/mem_bus_scheduler_if.sv
// Request/ack, serial output and response signals of the memory port
// scheduler. slave is the scheduler side, master the requester/pin side.
interface mem_bus_scheduler_if #(
  parameter int ADDR_BITS  = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic                 pf_req;
  logic [ADDR_BITS-1:0] pf_addr;
  logic                 pf_ack;
  logic                 pf_flush;
  logic                 rd_req;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 rd_ack;
  logic                 wr_req;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [7:0]           wr_data;
  logic                 wr_ack;
  logic [3:0]           tx_out;
  logic                 tx_active;
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 pf_resp_valid;
  logic                 rd_resp_valid;
  logic [7:0]           resp_data;
  logic [OCC_W-1:0]     outstanding;
  logic                 proto_error;

  modport slave (
    input  pf_req, pf_addr, pf_flush, rd_req, rd_addr,
    input  wr_req, wr_addr, wr_data, rx_valid, rx_data,
    output pf_ack, rd_ack, wr_ack, tx_out, tx_active,
    output pf_resp_valid, rd_resp_valid, resp_data, outstanding, proto_error
  );

  modport master (
    output pf_req, pf_addr, pf_flush, rd_req, rd_addr,
    output wr_req, wr_addr, wr_data, rx_valid, rx_data,
    input  pf_ack, rd_ack, wr_ack, tx_out, tx_active,
    input  pf_resp_valid, rd_resp_valid, resp_data, outstanding, proto_error
  );

endinterface

// File: rtl/mem_bus_scheduler_msg_type_fifo.sv
// Small FIFO of outstanding-response message types. Besides push/pop it can
// bulk-rewrite every entry holding one value into another in a single cycle,
// which is how in-flight prefetches are invalidated on a jump.
module msg_type_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       rewrite_en,
  input  logic [WIDTH-1:0]           rewrite_from,
  input  logic [WIDTH-1:0]           rewrite_to
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign head = entries[rd_ptr];

  // Storage, pointers and occupancy; a push lands after the rewrite so a
  // freshly pushed entry is never altered in its own cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rewrite_en && entries[i] == rewrite_from) entries[i] <= rewrite_to;
      end
      if (push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_scheduler.sv
// Arbitrates prefetch, data read and data write onto the nibble-wide memory
// port, serializes the granted transaction, and steers returning bytes.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no transaction on the pins; one request may be accepted
//   ST_SEND | shifting header/address/data nibbles out on tx_out
module mem_bus_scheduler
  import mem_bus_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_BITS  = 16
) (
  input logic                clk,
  input logic                rst_n,
  mem_bus_scheduler_if.slave bus
);

  localparam int ADDR_NIBS  = ADDR_BITS / 4;
  localparam int FRAME_NIBS = ADDR_NIBS + 3;
  localparam int FRAME_BITS = 4 * FRAME_NIBS;
  localparam int CNT_W      = $clog2(FRAME_NIBS + 1);
  localparam int OCC_W      = $clog2(FIFO_DEPTH) + 1;

  state_t                 state_q, state_d;
  logic [FRAME_BITS-1:0]  frame_q;
  logic [CNT_W-1:0]       nib_cnt_q;
  logic                   wr_ack_c, rd_ack_c, pf_ack_c;
  logic [OCC_W-1:0]       fifo_count;
  msg_t                   fifo_head;
  logic                   fifo_full, fifo_empty;
  logic                   fifo_push, fifo_pop;
  msg_t                   fifo_push_data;
  logic                   proto_error_q;

  // Occupancy is the registered count, so a same-cycle pop never opens a slot.
  assign fifo_full  = (fifo_count == OCC_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Accept arbitration (write > read > prefetch) and next state.
  always_comb begin
    state_d  = state_q;
    wr_ack_c = 1'b0;
    rd_ack_c = 1'b0;
    pf_ack_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst_n) begin
          if (bus.wr_req) begin
            wr_ack_c = 1'b1;
            state_d  = ST_SEND;
          end else if (bus.rd_req && !fifo_full) begin
            rd_ack_c = 1'b1;
            state_d  = ST_SEND;
          end else if (bus.pf_req && !fifo_full && !bus.pf_flush) begin
            pf_ack_c = 1'b1;
            state_d  = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (nib_cnt_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame shift register (header in the low nibble) and remaining-nibble
  // down-counter; the last nibble goes out while the counter reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q   <= '0;
      nib_cnt_q <= '0;
    end else if (wr_ack_c) begin
      frame_q   <= {bus.wr_data, bus.wr_addr, tx_header(TX_WR)};
      nib_cnt_q <= CNT_W'(FRAME_NIBS - 1);
    end else if (rd_ack_c) begin
      frame_q   <= {8'h00, bus.rd_addr, tx_header(TX_RD)};
      nib_cnt_q <= CNT_W'(ADDR_NIBS);
    end else if (pf_ack_c) begin
      frame_q   <= {8'h00, bus.pf_addr, tx_header(TX_PF)};
      nib_cnt_q <= CNT_W'(ADDR_NIBS);
    end else if (state_q == ST_SEND) begin
      frame_q <= frame_q >> 4;
      if (nib_cnt_q != '0) nib_cnt_q <= nib_cnt_q - 1'b1;
    end
  end

  assign fifo_push      = rd_ack_c || pf_ack_c;
  assign fifo_push_data = rd_ack_c ? MSG_RD : MSG_PF;
  assign fifo_pop       = bus.rx_valid && !fifo_empty;

  msg_type_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MSG_TYPE_BITS)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (fifo_push),
    .push_data    (fifo_push_data),
    .pop          (fifo_pop),
    .head         (fifo_head),
    .count        (fifo_count),
    .rewrite_en   (bus.pf_flush),
    .rewrite_from (MSG_PF),
    .rewrite_to   (MSG_DISCARD)
  );

  // Sticky flag for a response byte arriving with nothing outstanding.
  always_ff @(posedge clk) begin
    if (!rst_n)                           proto_error_q <= 1'b0;
    else if (bus.rx_valid && fifo_empty)  proto_error_q <= 1'b1;
  end

  assign bus.wr_ack        = wr_ack_c;
  assign bus.rd_ack        = rd_ack_c;
  assign bus.pf_ack        = pf_ack_c;
  assign bus.tx_active     = (state_q == ST_SEND);
  assign bus.tx_out        = (state_q == ST_SEND) ? frame_q[3:0] : 4'h0;
  // A prefetch head popped in a flush cycle is already stale.
  assign bus.pf_resp_valid = fifo_pop && (fifo_head == MSG_PF) && !bus.pf_flush;
  assign bus.rd_resp_valid = fifo_pop && (fifo_head == MSG_RD);
  assign bus.resp_data     = bus.rx_data;
  assign bus.outstanding   = fifo_count;
  assign bus.proto_error   = proto_error_q;

endmodule

// File: tb/tb_mem_bus_scheduler.sv
// Directed bench for mem_bus_scheduler: expected nibbles and response flags
// are queued by the stimulus and compared by an independent negedge monitor.
module tb_mem_bus_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] tx_q   [$];
  logic [9:0] resp_q [$];
  logic [3:0] exp_nib;
  logic [9:0] exp_resp;

  always #5 clk = ~clk;

  mem_bus_scheduler_if #(.ADDR_BITS(16), .FIFO_DEPTH(4)) bus ();

  mem_bus_scheduler #(.FIFO_DEPTH(4), .ADDR_BITS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h @%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.tx_active === 1'b1 && n < 30) begin
      tick();
      n++;
    end
    if (bus.tx_active !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle tx_active still %b after %0d cycles", bus.tx_active, n);
    end
  endtask

  task automatic push_pf_frame(input logic [15:0] a);
    tx_q.push_back(4'h9);
    for (int k = 0; k < 4; k++) tx_q.push_back(a[4*k +: 4]);
  endtask

  // Monitor: consumes one expected nibble per active tx cycle and one
  // expected {pf_valid, rd_valid, data} per rx_valid cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.tx_active === 1'b1) begin
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected got=%0h expected=none", bus.tx_out);
        end else begin
          exp_nib = tx_q.pop_front();
          check("tx_nibble", {28'h0, bus.tx_out}, {28'h0, exp_nib});
        end
      end else begin
        check("tx_idle_zero", {28'h0, bus.tx_out}, 32'h0);
      end
      if (bus.rx_valid === 1'b1) begin
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected got=%0h expected=none", bus.resp_data);
        end else begin
          exp_resp = resp_q.pop_front();
          check("resp", {22'h0, bus.pf_resp_valid, bus.rd_resp_valid, bus.resp_data},
                {22'h0, exp_resp});
        end
      end else begin
        check("resp_quiet", {30'h0, bus.pf_resp_valid, bus.rd_resp_valid}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.pf_req = 0; bus.pf_addr = '0; bus.pf_flush = 0;
    bus.rd_req = 0; bus.rd_addr = '0;
    bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rx_valid = 0; bus.rx_data = '0;

    // Reset state
    tick();
    mon_en = 1'b1;
    tick();
    @(negedge clk);
    check("rst_tx_active", {31'h0, bus.tx_active}, 32'h0);
    check("rst_outstanding", {29'h0, bus.outstanding}, 32'h0);
    check("rst_proto_error", {31'h0, bus.proto_error}, 32'h0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_acks", {29'h0, bus.wr_ack, bus.rd_ack, bus.pf_ack}, 32'h0);

    // Read 0x1234
    tick();
    bus.rd_req = 1; bus.rd_addr = 16'h1234;
    tx_q.push_back(4'hA); tx_q.push_back(4'h4); tx_q.push_back(4'h3);
    tx_q.push_back(4'h2); tx_q.push_back(4'h1);
    @(negedge clk);
    check("rd_ack", {31'h0, bus.rd_ack}, 32'h1);
    tick();
    bus.rd_req = 0;
    wait_idle();
    check("rd_outstanding", {29'h0, bus.outstanding}, 32'h1);
    bus.rx_valid = 1; bus.rx_data = 8'h5A;
    resp_q.push_back({2'b01, 8'h5A});
    tick();
    bus.rx_valid = 0;
    @(negedge clk);
    check("rd_drained", {29'h0, bus.outstanding}, 32'h0);

    // Write 0x00F0 <- 0xC3 with a prefetch pending
    tick();
    bus.wr_req = 1; bus.wr_addr = 16'h00F0; bus.wr_data = 8'hC3;
    bus.pf_req = 1; bus.pf_addr = 16'h0000;
    tx_q.push_back(4'hB); tx_q.push_back(4'h0); tx_q.push_back(4'hF);
    tx_q.push_back(4'h0); tx_q.push_back(4'h0); tx_q.push_back(4'h3);
    tx_q.push_back(4'hC);
    tx_q.push_back(4'h9); tx_q.push_back(4'h0); tx_q.push_back(4'h0);
    tx_q.push_back(4'h0); tx_q.push_back(4'h0);
    @(negedge clk);
    check("wr_ack_prio", {30'h0, bus.wr_ack, bus.pf_ack}, 32'h2);
    tick();
    bus.wr_req = 0;
    @(negedge clk);
    check("no_ack_in_send", {31'h0, bus.pf_ack}, 32'h0);
    wait_idle();
    @(negedge clk);
    check("pf_ack_after_wr", {31'h0, bus.pf_ack}, 32'h1);
    tick();
    bus.pf_req = 0;
    wait_idle();
    bus.rx_valid = 1; bus.rx_data = 8'h11;
    resp_q.push_back({2'b10, 8'h11});
    tick();
    bus.rx_valid = 0;

    // Fill the FIFO with four prefetches, hold a fifth
    for (int i = 0; i < 4; i++) begin
      bus.pf_req = 1; bus.pf_addr = 16'h1000 * i[15:0] + 16'h0010;
      push_pf_frame(16'h1000 * i[15:0] + 16'h0010);
      @(negedge clk);
      check("pf_fill_ack", {31'h0, bus.pf_ack}, 32'h1);
      tick();
      bus.pf_req = 0;
      wait_idle();
    end
    check("pf_full", {29'h0, bus.outstanding}, 32'h4);
    bus.pf_req = 1; bus.pf_addr = 16'h0050;
    @(negedge clk);
    check("pf_blocked_full", {31'h0, bus.pf_ack}, 32'h0);
    tick();
    bus.rx_valid = 1; bus.rx_data = 8'h01;
    resp_q.push_back({2'b10, 8'h01});
    @(negedge clk);
    check("pf_blocked_same_pop", {31'h0, bus.pf_ack}, 32'h0);
    tick();
    bus.rx_valid = 0;
    push_pf_frame(16'h0050);
    @(negedge clk);
    check("pf_ack_after_pop", {31'h0, bus.pf_ack}, 32'h1);
    tick();
    bus.pf_req = 0;
    wait_idle();
    check("pf_refull", {29'h0, bus.outstanding}, 32'h4);
    for (int i = 0; i < 4; i++) begin
      bus.rx_valid = 1; bus.rx_data = 8'h02 + i[7:0];
      resp_q.push_back({2'b10, 8'h02 + i[7:0]});
      tick();
    end
    bus.rx_valid = 0;
    check("pf_drained", {29'h0, bus.outstanding}, 32'h0);

    // Prefetch, read, prefetch, then flush
    bus.pf_req = 1; bus.pf_addr = 16'h0100;
    push_pf_frame(16'h0100);
    tick();
    bus.pf_req = 0;
    wait_idle();
    bus.rd_req = 1; bus.rd_addr = 16'h0200;
    tx_q.push_back(4'hA); tx_q.push_back(4'h0); tx_q.push_back(4'h0);
    tx_q.push_back(4'h2); tx_q.push_back(4'h0);
    tick();
    bus.rd_req = 0;
    wait_idle();
    bus.pf_req = 1; bus.pf_addr = 16'h0300;
    push_pf_frame(16'h0300);
    tick();
    bus.pf_req = 0;
    wait_idle();
    check("mix_outstanding", {29'h0, bus.outstanding}, 32'h3);
    bus.pf_flush = 1;
    tick();
    bus.pf_flush = 0;
    resp_q.push_back({2'b00, 8'hD1});
    resp_q.push_back({2'b01, 8'hD2});
    resp_q.push_back({2'b00, 8'hD3});
    for (int i = 0; i < 3; i++) begin
      bus.rx_valid = 1; bus.rx_data = 8'hD1 + i[7:0];
      tick();
    end
    bus.rx_valid = 0;
    check("flush_drained", {29'h0, bus.outstanding}, 32'h0);

    // Flush coinciding with a prefetch response at the head
    bus.pf_req = 1; bus.pf_addr = 16'h0A00;
    push_pf_frame(16'h0A00);
    tick();
    bus.pf_req = 0;
    wait_idle();
    bus.pf_flush = 1; bus.rx_valid = 1; bus.rx_data = 8'h77; bus.pf_req = 1;
    bus.pf_addr = 16'h0B00;
    resp_q.push_back({2'b00, 8'h77});
    @(negedge clk);
    check("pf_blocked_flush", {31'h0, bus.pf_ack}, 32'h0);
    tick();
    bus.pf_flush = 0; bus.rx_valid = 0; bus.pf_req = 0;
    @(negedge clk);
    check("flush_pop_outstanding", {29'h0, bus.outstanding}, 32'h0);

    // Response with nothing outstanding
    tick();
    bus.rx_valid = 1; bus.rx_data = 8'hEE;
    resp_q.push_back({2'b00, 8'hEE});
    tick();
    bus.rx_valid = 0;
    check("proto_error_set", {31'h0, bus.proto_error}, 32'h1);
    tick();
    check("proto_error_held", {31'h0, bus.proto_error}, 32'h1);

    // Read outstanding, then reset in the middle of a write
    bus.rd_req = 1; bus.rd_addr = 16'h4321;
    tx_q.push_back(4'hA); tx_q.push_back(4'h1); tx_q.push_back(4'h2);
    tx_q.push_back(4'h3); tx_q.push_back(4'h4);
    tick();
    bus.rd_req = 0;
    wait_idle();
    bus.wr_req = 1; bus.wr_addr = 16'h1111; bus.wr_data = 8'h22;
    tx_q.push_back(4'hB); tx_q.push_back(4'h1); tx_q.push_back(4'h1);
    tick();
    bus.wr_req = 0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_tx_active", {31'h0, bus.tx_active}, 32'h0);
    check("rst_mid_outstanding", {29'h0, bus.outstanding}, 32'h0);
    check("rst_mid_proto_error", {31'h0, bus.proto_error}, 32'h0);
    rst_n = 1'b1;
    tick();
    tick();

    check("tx_queue_empty", tx_q.size(), 32'h0);
    check("resp_queue_empty", resp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
